// File: rtl/xor_share_sched.sv
// Round-robin scheduler that time-shares one external 1-bit XOR gate, streaming operands LSB-first.
// Optional macro XOR_SELFCHECK_EN adds a sticky err flag comparing the gate output against a local XOR.
//
// state  | meaning
// IDLE   | no owner; arbitrate among pending requests
// SHIFT  | stream one operand bit pair per cycle through the gate
// DONE   | one-cycle result-valid pulse to the owner
module xor_share_sched #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] a_bus,
    input  logic [NREQ*WIDTH-1:0] b_bus,
    output logic                  xor_a,
    output logic                  xor_b,
    input  logic                  xor_out,
    output logic [NREQ-1:0]       grant,
    output logic                  busy,
    output logic [NREQ-1:0]       done,
    output logic [WIDTH-1:0]      result,
    output logic                  err
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [PW-1:0]    owner_q, owner_d;
    logic [NREQ-1:0]  grant_q, grant_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             sel_found;
    logic [PW-1:0]    sel_idx;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;

    // Scan from the entry after the last owner, wrapping, so the last owner gets lowest priority.
    always_comb begin : arb
        int scan_idx;
        scan_idx  = 0;
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            scan_idx = int'(ptr_q) + i;
            if (scan_idx >= NREQ) begin
                scan_idx = scan_idx - NREQ;
            end
            if (!sel_found && req[scan_idx]) begin
                sel_found = 1'b1;
                sel_idx   = PW'(scan_idx);
            end
        end
    end

    assign a_sel = a_bus[sel_idx*WIDTH +: WIDTH];
    assign b_sel = b_bus[sel_idx*WIDTH +: WIDTH];

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        grant_d  = grant_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (sel_found) begin
                    grant_d = NREQ'(1) << sel_idx;
                    owner_d = sel_idx;
                    sa_d    = a_sel;
                    sb_d    = b_sel;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (!req[owner_q]) begin
                    // Owner withdrew: release without a done pulse, result stays partial.
                    state_d = ST_IDLE;
                    grant_d = '0;
                    ptr_d   = owner_q;
                end else begin
                    result_d = {xor_out, result_q[WIDTH-1:1]};
                    sa_d     = sa_q >> 1;
                    sb_d     = sb_q >> 1;
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH-1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                grant_d = '0;
                ptr_d   = owner_q;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ptr_q    <= PW'(NREQ-1);
            owner_q  <= '0;
            grant_q  <= '0;
            sa_q     <= '0;
            sb_q     <= '0;
            result_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            grant_q  <= grant_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
        end
    end

    assign xor_a  = (state_q == ST_SHIFT) & sa_q[0];
    assign xor_b  = (state_q == ST_SHIFT) & sb_q[0];
    assign grant  = grant_q;
    assign busy   = (state_q != ST_IDLE);
    assign done   = (state_q == ST_DONE) ? grant_q : '0;
    assign result = result_q;

`ifdef XOR_SELFCHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q | ((state_q == ST_SHIFT) && (xor_out != (sa_q[0] ^ sb_q[0])));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: doc/xor_share_sched.md
Name: xor_share_sched

Overview:
Bit-serial scheduler that shares one external 1-bit XOR gate (the project-1 xor cell) among NREQ requesters. It arbitrates round-robin and latches the winner's two WIDTH-bit operands. It then streams operand bits LSB-first through the gate, one bit per cycle, and returns the assembled WIDTH-bit result with a one-cycle done pulse. It sits between requester logic and a single student_xor instance.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 8, operand/result width in bits (2..32)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
req  input  NREQ  request per requester; held high until its done pulse
a_bus  input  NREQ*WIDTH  operand A per requester; slice i = a_bus[i*WIDTH +: WIDTH]
b_bus  input  NREQ*WIDTH  operand B per requester, same slicing
xor_a  output  1  bit to XOR gate input a
xor_b  output  1  bit to XOR gate input b
xor_out  input  1  XOR gate output (combinational from xor_a/xor_b)
grant  output  NREQ  one-hot current owner; all zero when idle
busy  output  1  high in SHIFT and DONE
done  output  NREQ  one-cycle pulse to the owner when its result is valid
result  output  WIDTH  result; valid only during the done pulse, holds last value otherwise
err  output  1  sticky self-check error (see Optional Feature)

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; grant, done, result, err all 0; xor_a=xor_b=0.
  - bit counter = 0; rr pointer = NREQ-1, so requester 0 has first priority.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - If any req bit is set, select the first set bit scanning from ptr+1 upward with wrap.
  - At the clock edge: grant becomes one-hot on the selected index; that requester's a/b slices load into shift regs sa/sb; counter=0; state=SHIFT.
  - If no req is set, remain in IDLE.
- SHIFT:
  - xor_a=sa[0], xor_b=sb[0] (registered bits; gate is sampled in the same cycle).
  - Each edge: result <= {xor_out, result[WIDTH-1:1]}; sa/sb shift right; counter++.
  - After WIDTH edges (counter==WIDTH-1 at the edge), go to DONE.
- DONE (one cycle):
  - done[owner]=1; result = a^b of the latched operands.
  - Next edge: ptr=owner, grant=0, state=IDLE.
- Latency: req sampled in IDLE at cycle 0 -> grant from cycle 1 -> done in cycle WIDTH+1. Minimum spacing between grants to successive requesters is WIDTH+2 cycles, because IDLE is always one cycle.
- Operand changes on a_bus/b_bus after the grant edge are ignored (operands are latched).
- Abort: if req[owner] drops during SHIFT, the next edge goes to IDLE with no done pulse and ptr=owner. result is left partially shifted.
- req dropping during DONE: done still pulses.
- Requests from non-owners during SHIFT/DONE are held off and never lost while req stays high.
- Simultaneous requests: round-robin guarantees each continuously requesting index is served within NREQ grants.
- xor_a/xor_b are 0 outside SHIFT.
- Reset asserted mid-SHIFT returns everything to reset values immediately, with no done pulse.

Optional Feature:
XOR_SELFCHECK_EN
- Defined: each SHIFT cycle compares xor_out against sa[0]^sb[0]. Any mismatch sets err at the next edge. err is sticky until reset; operation is otherwise unaffected.
- Undefined: no compare logic; err is tied to 0.

Test Plan:
1. NREQ=4, WIDTH=4, correct XOR gate. req=0001, a0=4'b1010, b0=4'b0110 at cycle 0 -> grant=0001 in cycles 1..5; xor_a/xor_b sequence (0,0),(1,1),(0,1),(1,0); done=0001 in cycle 5; result=4'b1100; grant=0 in cycle 6.
2. req=1111 held, all operands 4'hF/4'h0 -> grants in order 0001,0010,0100,1000,0001; each done paired with result 4'hF; done pulses 6 cycles apart.
3. Abort: req=0100 (a2=4'h5, b2=4'h3); drop req[2] in cycle 3 -> no done pulse, grant=0 by cycle 4. A following req=0100 is granted after the one idle cycle and gives result 4'h6.
4. Reset mid-op: assert rst_n=0 during SHIFT cycle 2 -> grant, busy, done, result, xor_a, xor_b = 0 with no clock edge needed. After release, req=0001 is served as in test 1.
5. Priority wrap: after serving index 3, assert req=1001 together -> index 0 is granted first, then index 3.
6. XOR_SELFCHECK_EN defined, XOR gate replaced by an OR model, a0=4'b0011, b0=4'b0001 -> err=1 after the first SHIFT edge (bit 0: 1 vs 0) and stays 1. With the macro undefined -> err=0 throughout.
